// File: rtl/spi_dac_sample_feeder_pkg.sv
// ---------------------------------------------------------------------------
// spi_dac_sample_feeder_pkg
// Shared definitions for the DAC sample feeder. This package provides:
//   - feeder_state_t     : launch FSM state encoding (IDLE, LAUNCH,
//                          WAIT_CS_HIGH, GUARD)
//   - MID_SCALE          : offset-binary mid-scale code, which is the idle
//                          value of the DAC byte
//   - to_offset_binary() : converts a signed two's-complement sample to an
//                          offset-binary DAC code
// ---------------------------------------------------------------------------
package spi_dac_sample_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    LAUNCH       = 2'd1,
    WAIT_CS_HIGH = 2'd2,
    GUARD        = 2'd3
  } feeder_state_t;

  localparam logic [7:0] MID_SCALE = 8'h80;

  // Flipping the sign bit maps -128..127 onto 0x00..0xFF.
  function automatic logic [7:0] to_offset_binary(input logic [7:0] sample);
    return {~sample[7], sample[6:0]};
  endfunction

endpackage

// File: rtl/spi_dac_sample_feeder_sync_fifo_2x8.sv
// ---------------------------------------------------------------------------
// sync_fifo_2x8
// Two-entry, 8-bit synchronous FIFO. The head entry is shown ahead, so dout
// is valid whenever the FIFO is not empty.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-low reset, which empties the FIFO
//   push   : write din this cycle. The write is ignored when the FIFO is
//            full, unless pop is also active.
//   pop    : drop the head entry this cycle. The pop is ignored when the
//            FIFO is empty.
//   din    : write data
//   dout   : head entry
//   full   : the FIFO holds 2 entries
//   empty  : the FIFO holds 0 entries
//   count  : number of entries held (0..2)
// ---------------------------------------------------------------------------
module sync_fifo_2x8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  logic [7:0] mem_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count_reg != 2'd0);
  // When the FIFO is full, a write is still accepted if the head leaves in
  // the same cycle. When full, wr_ptr equals rd_ptr. The slot being
  // overwritten is the one that dout presents during this cycle.
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        mem_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= din;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign full  = (count_reg == 2'd2);
  assign empty = (count_reg == 2'd0);
  assign count = count_reg;

endmodule

// File: rtl/spi_dac_sample_feeder.sv
// ---------------------------------------------------------------------------
// spi_dac_sample_feeder
// Accepts signed wave samples and converts them to offset binary. Each
// converted byte is queued in a 2-entry FIFO. The block then launches one
// SPI byte per sample toward an SPI master. It paces the launches by
// watching the master's CS line, which is fed back to this block. No launch
// strobe is issued while the master is busy. Each launch is followed by
// GUARD_CLKS idle clocks.
// Ports:
//   clk_i                 : system clock
//   rst_i                 : synchronous active-low reset
//   sample_i              : signed two's-complement sample
//   sample_valid_strobe_i : one-cycle strobe that qualifies sample_i
//   spi_cs_i              : CS line of the SPI master (high = idle)
//   data_o                : offset-binary byte to the master. It is held
//                           between launches.
//   data_valid_strobe_o   : one-cycle launch strobe to the master
//   overflow_o            : sticky flag that means a sample was dropped
//                           because the FIFO was full
//   busy_o                : high while data is queued or a launch is in
//                           progress
// ---------------------------------------------------------------------------
module spi_dac_sample_feeder
  import spi_dac_sample_feeder_pkg::*;
#(
  parameter int BITWIDTH       = 8,  // fixed at 8: one SPI byte per sample
  parameter int GUARD_CLKS     = 3,
  parameter int CS_LOW_TIMEOUT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [BITWIDTH-1:0] sample_i,
  input  logic                sample_valid_strobe_i,
  input  logic                spi_cs_i,
  output logic [BITWIDTH-1:0] data_o,
  output logic                data_valid_strobe_o,
  output logic                overflow_o,
  output logic                busy_o
);

  localparam int TW = $clog2(CS_LOW_TIMEOUT + 1);
  localparam int GW = $clog2(GUARD_CLKS + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(CS_LOW_TIMEOUT - 1);
  localparam logic [GW-1:0] GUARD_LOAD   = GW'(GUARD_CLKS);
  localparam logic [GW-1:0] GUARD_ONE    = GW'(1);

  feeder_state_t state_reg;
  logic [7:0]    data_reg;
  logic          strobe_reg;
  logic          overflow_reg;
  logic          retry_reg;
  logic [TW-1:0] timeout_cnt_reg;
  logic [GW-1:0] guard_cnt_reg;

  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_count;
  logic          launch_new;
  logic          drop_sample;

  // A fresh byte is launched only from IDLE, only with the master idle, and
  // only when no earlier launch is waiting to be retried.
  assign launch_new  = (state_reg == IDLE) && !retry_reg && spi_cs_i && !fifo_empty;
  assign drop_sample = sample_valid_strobe_i && fifo_full && !launch_new;

  sync_fifo_2x8 u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (sample_valid_strobe_i),
    .pop   (launch_new),
    .din   (to_offset_binary(sample_i)),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg       <= IDLE;
      data_reg        <= MID_SCALE;
      strobe_reg      <= 1'b0;
      overflow_reg    <= 1'b0;
      retry_reg       <= 1'b0;
      timeout_cnt_reg <= '0;
      guard_cnt_reg   <= '0;
    end else begin
      strobe_reg <= 1'b0;
      if (drop_sample) overflow_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (retry_reg && spi_cs_i) begin
            // The previous launch was never acknowledged. Resend the byte
            // that data_reg still holds. No new FIFO entry is consumed.
            strobe_reg      <= 1'b1;
            retry_reg       <= 1'b0;
            timeout_cnt_reg <= '0;
            state_reg       <= LAUNCH;
          end else if (launch_new) begin
            data_reg        <= fifo_head;
            strobe_reg      <= 1'b1;
            timeout_cnt_reg <= '0;
            state_reg       <= LAUNCH;
          end
        end

        LAUNCH: begin
          if (!spi_cs_i) begin
            timeout_cnt_reg <= '0;
            state_reg       <= WAIT_CS_HIGH;
          end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
            // The master did not take the byte. The retry flag is set once
            // for each expiry, and the byte stays in data_reg.
            timeout_cnt_reg <= '0;
            retry_reg       <= 1'b1;
            state_reg       <= IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
        end

        WAIT_CS_HIGH: begin
          if (spi_cs_i) begin
            guard_cnt_reg <= GUARD_LOAD;
            state_reg     <= GUARD;
          end
        end

        GUARD: begin
          // The FSM stays here GUARD_CLKS cycles and then returns to IDLE.
          if (guard_cnt_reg <= GUARD_ONE) begin
            guard_cnt_reg <= '0;
            state_reg     <= IDLE;
          end else begin
            guard_cnt_reg <= guard_cnt_reg - 1'b1;
          end
        end

        default: begin
          strobe_reg <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign data_o              = data_reg;
  assign data_valid_strobe_o = strobe_reg;
  assign overflow_o          = overflow_reg;
  assign busy_o              = (fifo_count != 2'd0) || (state_reg != IDLE) || retry_reg;

endmodule

// File: tb/tb_spi_dac_sample_feeder.sv
// ---------------------------------------------------------------------------
// tb_spi_dac_sample_feeder
// Testbench for spi_dac_sample_feeder. It contains:
//   - a stimulus process that drives the samples
//   - a behavioural CS responder that stands in for the SPI master. The
//     responder can be disconnected.
//   - a scoreboard monitor. It keeps the expected launch queue and the
//     sticky overflow flag, and checks every launch and every held output.
// ---------------------------------------------------------------------------
module tb_spi_dac_sample_feeder;

  localparam int GUARD_CLKS     = 3;
  localparam int CS_LOW_TIMEOUT = 4;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] sample_i;
  logic       sample_valid_strobe_i;
  logic       spi_cs_i;
  logic [7:0] data_o;
  logic       data_valid_strobe_o;
  logic       overflow_o;
  logic       busy_o;

  spi_dac_sample_feeder #(
    .BITWIDTH       (8),
    .GUARD_CLKS     (GUARD_CLKS),
    .CS_LOW_TIMEOUT (CS_LOW_TIMEOUT)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .sample_i              (sample_i),
    .sample_valid_strobe_i (sample_valid_strobe_i),
    .spi_cs_i              (spi_cs_i),
    .data_o                (data_o),
    .data_valid_strobe_o   (data_valid_strobe_o),
    .overflow_o            (overflow_o),
    .busy_o                (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion: the DAC code is the signed value shifted up by
  // half scale.
  function automatic logic [7:0] ref_code(input logic [7:0] s);
    int v;
    v = $signed(s);
    return 8'(v + 128);
  endfunction

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];        // accepted samples waiting for a launch
  logic       ovf_exp   = 1'b0;
  logic [7:0] held_byte = 8'h80;
  bit         awaiting  = 1'b0; // launch issued, CS not yet seen low
  bit         xfer      = 1'b0; // CS currently low because of our launch
  bit         low_xfer  = 1'b0; // last CS-low period was a real transfer
  bit         prev_strobe = 1'b0;
  int         cyc = 0;
  int         last_cyc = 0;
  int         hi_cnt = 1000;

  // ---------------- CS responder (master stand-in) ----------------
  bit connected  = 1'b1;
  bit force_low  = 1'b0;
  int rstate     = 0;
  int rdly;
  int rlen;

  initial begin
    spi_cs_i = 1'b1;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i) begin
        spi_cs_i = 1'b1;
        rstate   = 0;
      end else if (force_low) begin
        spi_cs_i = 1'b0;
      end else begin
        case (rstate)
          0: begin
            spi_cs_i = 1'b1;
            if (connected && data_valid_strobe_o) begin
              rdly = $urandom_range(0, 2);
              rlen = $urandom_range(4, 16);
              if (rdly == 0) begin
                spi_cs_i = 1'b0;
                rstate   = 2;
              end else begin
                rstate = 1;
              end
            end
          end
          1: begin
            rdly--;
            if (rdly == 0) begin
              spi_cs_i = 1'b0;
              rstate   = 2;
            end
          end
          default: begin
            rlen--;
            if (rlen == 0) begin
              spi_cs_i = 1'b1;
              rstate   = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk_i) begin
    bit         popped;
    logic [7:0] exp_b;
    #1;
    cyc++;
    if (!rst_i) begin
      exp_q.delete();
      ovf_exp     = 1'b0;
      held_byte   = 8'h80;
      awaiting    = 1'b0;
      xfer        = 1'b0;
      low_xfer    = 1'b0;
      prev_strobe = 1'b0;
      hi_cnt      = 1000;
      chk("reset_strobe", data_valid_strobe_o, 0);
      chk("reset_data", data_o, 8'h80);
      chk("reset_overflow", overflow_o, 0);
      chk("reset_busy", busy_o, 0);
    end else begin
      popped = 1'b0;
      if (!spi_cs_i) begin
        if (awaiting) begin
          awaiting = 1'b0;
          xfer     = 1'b1;
        end
        low_xfer = xfer;
        hi_cnt   = 0;
      end else begin
        xfer = 1'b0;
        if (hi_cnt < 1000) hi_cnt++;
      end

      if (data_valid_strobe_o) begin
        chk("strobe_not_back_to_back", prev_strobe, 0);
        chk("launch_with_cs_idle", spi_cs_i, 1);
        chk("busy_during_launch", busy_o, 1);
        if (awaiting) begin
          chk("retry_same_byte", data_o, held_byte);
          chk("retry_period", cyc - last_cyc, CS_LOW_TIMEOUT + 1);
        end else begin
          if (low_xfer) chk("guard_clocks_elapsed", int'(hi_cnt >= GUARD_CLKS + 1), 1);
          chk("launch_has_pending_sample", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            chk("launch_byte", data_o, exp_b);
            held_byte = exp_b;
            popped    = 1'b1;
          end
        end
        awaiting = 1'b1;
        last_cyc = cyc;
      end else begin
        chk("data_held", data_o, held_byte);
      end

      if (sample_valid_strobe_i) begin
        if (exp_q.size() < 2 || popped) exp_q.push_back(ref_code(sample_i));
        else ovf_exp = 1'b1;
      end
      chk("overflow_flag", overflow_o, ovf_exp);
      prev_strobe = data_valid_strobe_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [7:0] s);
    @(negedge clk_i);
    sample_valid_strobe_i = v;
    sample_i              = s;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      #2;
      n++;
    end while (n < 800 && !(busy_o == 1'b0 && rstate == 0 && exp_q.size() == 0 && spi_cs_i));
    chk("quiet_within_budget", int'(n < 800), 1);
    chk("idle_busy_low", busy_o, 0);
  endtask

  initial begin
    int n;
    bit seen;
    rst_i                 = 1'b0;
    sample_valid_strobe_i = 1'b1;
    sample_i              = 8'h33;

    // Reset held for 3 clocks with samples arriving.
    repeat (3) begin
      @(negedge clk_i);
      sample_i = 8'($urandom);
    end
    @(negedge clk_i);
    rst_i                 = 1'b1;
    sample_valid_strobe_i = 1'b0;

    // Single sample 0x00 on an idle link: the launch follows 2 clocks later.
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    @(posedge clk_i);
    #2;
    chk("latency_strobe", data_valid_strobe_o, 1);
    chk("latency_data", data_o, 8'h80);
    wait_quiet();

    // Back-to-back samples 0x7F and 0x80 produce bytes 0xFF and 0x00.
    drive(1'b1, 8'h7F);
    drive(1'b1, 8'h80);
    drive(1'b0, 8'h00);
    wait_quiet();

    // FIFO full while CS is held low, then a push arrives together with the
    // first pop.
    @(negedge clk_i);
    force_low = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h10);
    drive(1'b1, 8'h20);
    @(negedge clk_i);
    force_low             = 1'b0;
    sample_valid_strobe_i = 1'b1;
    sample_i              = 8'h30;
    drive(1'b0, 8'h00);
    @(negedge clk_i);
    chk("simul_push_pop_no_overflow", overflow_o, 0);
    wait_quiet();

    // Overflow: three samples pushed during one transfer.
    drive(1'b1, 8'h01);
    drive(1'b0, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      if (data_valid_strobe_o) seen = 1'b1;
    end
    chk("first_launch_seen", int'(seen), 1);
    sample_valid_strobe_i = 1'b1;
    sample_i              = 8'h02;
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h04);
    drive(1'b0, 8'h00);
    @(negedge clk_i);
    chk("overflow_set", overflow_o, 1);
    wait_quiet();
    chk("overflow_sticky", overflow_o, 1);

    // CS timeout: the master is disconnected, so the same byte is retried.
    connected = 1'b0;
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h11);
    drive(1'b0, 8'h00);
    n = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (data_valid_strobe_o) n++;
    end
    chk("retries_seen", int'(n >= 4), 1);
    connected = 1'b1;
    wait_quiet();

    // Random traffic with a reset in the middle of a transfer.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
      end
      drive(($urandom_range(0, 4) == 0), 8'($urandom));
    end
    drive(1'b0, 8'h00);
    wait_quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
